// File: rtl/switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module  : switch_allocator_if
// Brief   : Router switch-allocator bundle: requests, destinations, output
//           readiness, crossbar handshake and grant/status outputs.
//           Grant_cnt exists only when SWALLOC_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
interface switch_allocator_if;
  logic [4:0]  Req;
  logic [2:0]  Dest_W;
  logic [2:0]  Dest_E;
  logic [2:0]  Dest_N;
  logic [2:0]  Dest_S;
  logic [2:0]  Dest_PE;
  logic [4:0]  Out_ready;
  logic        W_SW_DONE;
  logic        E_SW_DONE;
  logic        N_SW_DONE;
  logic        S_SW_DONE;
  logic        PE_SW_DONE;
  logic        Cross_EN;
  logic [4:0]  In_Out_Sel;
  logic [4:0]  Grant;
  logic        Err_done;
  logic        Busy;
`ifdef SWALLOC_STATS_EN
  logic [15:0] Grant_cnt;
`endif

  // Allocator side
  modport master (
    input  Req, Dest_W, Dest_E, Dest_N, Dest_S, Dest_PE, Out_ready,
    input  W_SW_DONE, E_SW_DONE, N_SW_DONE, S_SW_DONE, PE_SW_DONE,
    output Cross_EN, In_Out_Sel, Grant, Err_done, Busy
`ifdef SWALLOC_STATS_EN
    , output Grant_cnt
`endif
  );

  // Router / crossbar side
  modport slave (
    output Req, Dest_W, Dest_E, Dest_N, Dest_S, Dest_PE, Out_ready,
    output W_SW_DONE, E_SW_DONE, N_SW_DONE, S_SW_DONE, PE_SW_DONE,
    input  Cross_EN, In_Out_Sel, Grant, Err_done, Busy
`ifdef SWALLOC_STATS_EN
    , input Grant_cnt
`endif
  );
endinterface
`default_nettype wire

// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
// Module  : switch_allocator
// Brief   : 5-port round-robin switch allocator with crossbar handshake
//           (IDLE -> ISSUE -> CHECK). Optional SWALLOC_STATS_EN adds a
//           saturating 16-bit grant counter.
// Revision: 1.0 - initial release
// ============================================================================
module switch_allocator #(
  parameter logic [2:0] PTR_INIT = 3'd4
) (
  input  logic               CLK,
  input  logic               RST,
  switch_allocator_if.master sw
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_cross_en, w_cross_en_nxt;
  logic [4:0] r_in_out_sel, w_in_out_sel_nxt;
  logic [4:0] r_grant, w_grant_nxt;
  logic       r_err_done, w_err_done_nxt;
  logic       r_busy;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic [2:0] r_sel_in, w_sel_in_nxt;

  logic [2:0] w_dest [5];
  logic [4:0] w_elig;
  logic       w_found;
  logic [2:0] w_win;
  logic [2:0] w_idx;
  logic       w_done;

  assign w_dest[0] = sw.Dest_W;
  assign w_dest[1] = sw.Dest_E;
  assign w_dest[2] = sw.Dest_N;
  assign w_dest[3] = sw.Dest_S;
  assign w_dest[4] = sw.Dest_PE;

  // Destination is range-checked before it is used to pick a ready bit.
  for (genvar gi = 0; gi < 5; gi++) begin : g_elig
    assign w_elig[gi] = sw.Req[gi]
                        && (w_dest[gi] <= 3'd4)
                        && !((gi == 4) && (w_dest[gi] == 3'd4))
                        && sw.Out_ready[w_dest[gi]]
                        && !r_grant[gi];
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < 5; k++) begin
      w_idx = (w_idx == 3'd4) ? 3'd0 : w_idx + 3'd1;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Done flags are sticky, so only the winner's flag is meaningful in CHECK.
  always_comb begin
    w_done = 1'b0;
    case (r_sel_in)
      3'd0:    w_done = sw.W_SW_DONE;
      3'd1:    w_done = sw.E_SW_DONE;
      3'd2:    w_done = sw.N_SW_DONE;
      3'd3:    w_done = sw.S_SW_DONE;
      3'd4:    w_done = sw.PE_SW_DONE;
      default: w_done = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cross_en_nxt   = 1'b0;
    w_in_out_sel_nxt = r_in_out_sel;
    w_sel_in_nxt     = r_sel_in;
    w_grant_nxt      = 5'd0;
    w_err_done_nxt   = 1'b0;
    w_ptr_nxt        = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_sel_in_nxt     = w_win;
          w_in_out_sel_nxt = 5'(w_win) * 5'd5 + {2'b00, w_dest[w_win]};
          w_cross_en_nxt   = 1'b1;
          w_state_nxt      = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        if (w_done) begin
          w_grant_nxt = 5'd1 << r_sel_in;
          w_ptr_nxt   = r_sel_in;
        end else begin
          w_err_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_cross_en   <= 1'b0;
      r_in_out_sel <= 5'd0;
      r_grant      <= 5'd0;
      r_err_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_ptr        <= PTR_INIT;
      r_sel_in     <= 3'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_cross_en   <= w_cross_en_nxt;
      r_in_out_sel <= w_in_out_sel_nxt;
      r_grant      <= w_grant_nxt;
      r_err_done   <= w_err_done_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_ptr        <= w_ptr_nxt;
      r_sel_in     <= w_sel_in_nxt;
    end
  end

  assign sw.Cross_EN   = r_cross_en;
  assign sw.In_Out_Sel = r_in_out_sel;
  assign sw.Grant      = r_grant;
  assign sw.Err_done   = r_err_done;
  assign sw.Busy       = r_busy;

`ifdef SWALLOC_STATS_EN
  logic [15:0] r_grant_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_grant_cnt <= 16'd0;
    end else if ((|w_grant_nxt) && (r_grant_cnt != 16'hFFFF)) begin
      r_grant_cnt <= r_grant_cnt + 16'd1;
    end
  end

  assign sw.Grant_cnt = r_grant_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module  : tb_switch_allocator
// Brief   : Scoreboard bench for switch_allocator with a sticky-flag
//           crossbar model and directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;
  int   cyc;

  switch_allocator_if sw ();

  switch_allocator #(.PTR_INIT(3'd4)) dut (
    .CLK (CLK),
    .RST (RST),
    .sw  (sw)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Crossbar model: flags are sticky until the next enable.
  logic       resp_en;
  logic [4:0] done_r;
  always @(posedge CLK or negedge RST) begin
    if (!RST) done_r <= 5'd0;
    else if (sw.Cross_EN) done_r <= resp_en ? (5'd1 << (sw.In_Out_Sel / 5'd5)) : 5'd0;
  end
  assign sw.W_SW_DONE  = done_r[0];
  assign sw.E_SW_DONE  = done_r[1];
  assign sw.N_SW_DONE  = done_r[2];
  assign sw.S_SW_DONE  = done_r[3];
  assign sw.PE_SW_DONE = done_r[4];

  localparam int K_XFER = 0;
  localparam int K_GNT  = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int         kind;
    logic [4:0] val;
  } exp_t;

  exp_t q[$];
  int   last_xen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [4:0] val);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d actual_val=%0d expected=none", kind, val);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val) begin
        failures++;
        $display("FAIL event actual_kind=%0d actual_val=%0d expected_kind=%0d expected_val=%0d",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // Monitor / scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      if (sw.Cross_EN) begin
        if (last_xen == cyc - 1) chk("cross_en_back_to_back", 1, 0);
        last_xen = cyc;
        pop_cmp(K_XFER, sw.In_Out_Sel);
      end
      if (sw.Grant != 5'd0) pop_cmp(K_GNT, sw.Grant);
      if (sw.Err_done) pop_cmp(K_ERR, 5'd0);
      if (sw.Grant != 5'd0 && sw.Err_done) chk("grant_and_err_same_cycle", 1, 0);
    end
  end

  task automatic do_reset();
    RST = 1'b0;
    sw.Req = 5'd0;
    repeat (2) @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (q.size() == 0) break;
      @(posedge CLK);
    end
    #1 chk(name, q.size(), 0);
    q.delete();
  endtask

  int xq[$];

  initial begin
    checks = 0; failures = 0; cyc = 0; last_xen = -10;
    resp_en = 1'b1;
    sw.Req = 5'd0; sw.Out_ready = 5'b11111;
    sw.Dest_W = 3'd0; sw.Dest_E = 3'd0; sw.Dest_N = 3'd0; sw.Dest_S = 3'd0; sw.Dest_PE = 3'd0;
    RST = 1'b0;
    #12;
    // Reset state
    chk("rst_cross_en", int'(sw.Cross_EN), 0);
    chk("rst_in_out_sel", int'(sw.In_Out_Sel), 0);
    chk("rst_grant", int'(sw.Grant), 0);
    chk("rst_err_done", int'(sw.Err_done), 0);
    chk("rst_busy", int'(sw.Busy), 0);
    do_reset();

    // Single request: W -> E
    sw.Req = 5'b00001; sw.Dest_W = 3'd1;
    push(K_XFER, 5'd1); push(K_GNT, 5'b00001);
    @(negedge CLK); chk("single_k_cross_en", int'(sw.Cross_EN), 0);
    @(posedge CLK); #2 sw.Req = 5'd0;
    @(negedge CLK); chk("single_k1_cross_en", int'(sw.Cross_EN), 1);
    chk("single_k1_sel", int'(sw.In_Out_Sel), 1);
    chk("single_k1_busy", int'(sw.Busy), 1);
    @(negedge CLK); chk("single_k2_grant", int'(sw.Grant), 0);
    chk("single_k2_cross_en", int'(sw.Cross_EN), 0);
    @(negedge CLK); chk("single_k3_grant", int'(sw.Grant), 1);
    chk("single_k3_busy", int'(sw.Busy), 0);
`ifdef SWALLOC_STATS_EN
    chk("single_grant_cnt", int'(sw.Grant_cnt), 1);
`endif
    wait_drain("single_drain", 10);

    // Round-robin fairness from ptr=4
    do_reset();
    sw.Dest_W = 3'd2; sw.Dest_E = 3'd2; sw.Dest_N = 3'd2; sw.Dest_S = 3'd2; sw.Dest_PE = 3'd0;
    push(K_XFER, 5'd2);  push(K_GNT, 5'b00001);
    push(K_XFER, 5'd7);  push(K_GNT, 5'b00010);
    push(K_XFER, 5'd12); push(K_GNT, 5'b00100);
    push(K_XFER, 5'd17); push(K_GNT, 5'b01000);
    push(K_XFER, 5'd20); push(K_GNT, 5'b10000);
    push(K_XFER, 5'd2);  push(K_GNT, 5'b00001);
    sw.Req = 5'b11111;
    xq.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (sw.Cross_EN) xq.push_back(c);
      if (c == 15) begin
        @(posedge CLK);
        #2 sw.Req = 5'd0;
      end
    end
    chk("rr_xen_count", xq.size(), 6);
    for (int i = 0; i < xq.size(); i++) chk("rr_xen_cycle", xq[i], 1 + 3 * i);
    wait_drain("rr_drain", 10);

    // Masking by Out_ready
    @(posedge CLK); #2;
    sw.Req = 5'b00010; sw.Dest_E = 3'd4; sw.Out_ready = 5'b01111;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("mask_no_cross_en", int'(sw.Cross_EN) + int'(sw.Busy), 0);
    end
    push(K_XFER, 5'd9); push(K_GNT, 5'b00010);
    @(posedge CLK); #2 sw.Out_ready = 5'b11111;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
        @(negedge CLK);
        seen = sw.Cross_EN;
      end
      chk("mask_cross_en_seen", int'(seen), 1);
    end
    @(posedge CLK); #2 sw.Req = 5'd0;
    wait_drain("mask_drain", 10);

    // Illegal destinations
    @(posedge CLK); #2 sw.Req = 5'b10000; sw.Dest_PE = 3'd4;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("illegal_pe_pe", {29'd0, sw.Busy, sw.Cross_EN, |sw.Grant}, 0);
    end
    @(posedge CLK); #2 sw.Req = 5'b00001; sw.Dest_W = 3'd6;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk("illegal_dest6", {29'd0, sw.Busy, sw.Cross_EN, |sw.Grant}, 0);
    end
    @(posedge CLK); #2 sw.Req = 5'd0;

    // Missing done: errors, pointer unchanged
    do_reset();
    resp_en = 1'b0;
    sw.Req = 5'b00100; sw.Dest_N = 3'd3;
    push(K_XFER, 5'd13); push(K_ERR, 5'd0);
    push(K_XFER, 5'd13); push(K_ERR, 5'd0);
    repeat (4) @(posedge CLK);
    #2 sw.Req = 5'd0;
    wait_drain("nodone_drain", 12);
    resp_en = 1'b1;
    @(posedge CLK); #2;
    sw.Dest_W = 3'd1; sw.Dest_S = 3'd0; sw.Req = 5'b01001;
    push(K_XFER, 5'd1);  push(K_GNT, 5'b00001);
    push(K_XFER, 5'd15); push(K_GNT, 5'b01000);
    repeat (4) @(posedge CLK);
    #2 sw.Req = 5'd0;
    wait_drain("ptr_kept_drain", 12);

    // Reset while in CHECK aborts the transfer
    @(posedge CLK); #2 sw.Req = 5'b00001; sw.Dest_W = 3'd1;
    push(K_XFER, 5'd1);
    @(posedge CLK); #2 sw.Req = 5'd0;
    @(posedge CLK); #2 RST = 1'b0;
    #1;
    chk("abort_cross_en", int'(sw.Cross_EN), 0);
    chk("abort_in_out_sel", int'(sw.In_Out_Sel), 0);
    chk("abort_grant", int'(sw.Grant), 0);
    chk("abort_err_done", int'(sw.Err_done), 0);
    chk("abort_busy", int'(sw.Busy), 0);
`ifdef SWALLOC_STATS_EN
    chk("abort_grant_cnt", int'(sw.Grant_cnt), 0);
`endif
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    repeat (6) @(posedge CLK);
    wait_drain("abort_drain", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter: PTR_INIT, default 4, reset value of the round-robin pointer (0..4).
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous active-low reset.
REQ-004 Req  in  5  per-input request; bit index 0=W, 1=E, 2=N, 3=S, 4=PE.
REQ-005 Dest_W, Dest_E, Dest_N, Dest_S, Dest_PE  in  3 each  requested output; 0=W, 1=E, 2=N, 3=S, 4=PE.
REQ-006 Out_ready  in  5  per-output downstream ready; same bit order as Req.
REQ-007 W_SW_DONE, E_SW_DONE, N_SW_DONE, S_SW_DONE, PE_SW_DONE  in  1 each  crossbar completion flags.
REQ-008 Cross_EN  out  1  crossbar enable; one-cycle pulse per transfer.
REQ-009 In_Out_Sel  out  5  crossbar select code = 5*input + output.
REQ-010 Grant  out  5  one-hot, one-cycle pulse; the input may pop its flit.
REQ-011 Err_done  out  1  one-cycle pulse when the crossbar fails to confirm a transfer.
REQ-012 Busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE and CHECK; all outputs SHALL be registered.
REQ-014 Input i SHALL be eligible when all of the following hold:
- Req[i]=1
- Dest_i<=4
- (i,Dest_i) is not (PE,PE)
- Out_ready[Dest_i]=1
- Grant[i]=0 in the current cycle
REQ-015 Ineligible requests (illegal destination or output not ready) SHALL be ignored, with no error indication.
REQ-016 In IDLE, arbitration SHALL be round-robin: search order ptr+1, ptr+2, ... ptr, all mod 5; the first eligible input wins.
REQ-017 IDLE with a winner: register sel_in and sel_out, set In_Out_Sel=5*sel_in+sel_out and Cross_EN=1, then go to ISSUE.
REQ-018 IDLE with no winner: remain in IDLE with Cross_EN=0.
REQ-019 ISSUE: Cross_EN<=0, In_Out_Sel held, then go to CHECK unconditionally.
REQ-020 CHECK, done flag for sel_in=1: Grant[sel_in]<=1 for one cycle, ptr<=sel_in, go to IDLE.
REQ-021 CHECK, done flag for sel_in=0: Err_done<=1 for one cycle, ptr unchanged, no Grant, go to IDLE.
REQ-022 The done flag SHALL be sampled only at the end of CHECK, because the flags are sticky between crossbar enables.
REQ-023 Latency: request eligible in cycle k -> Cross_EN high in k+1 -> Grant high in k+3.
REQ-024 Peak throughput SHALL be one transfer per 3 cycles.
REQ-025 Req, Dest and Out_ready changes during ISSUE or CHECK SHALL have no effect on the transfer in flight.
REQ-026 Simultaneous requests to the same output SHALL yield exactly one winner, chosen per REQ-016.
REQ-027 Grant and Err_done SHALL never be asserted in the same cycle.
REQ-028 Cross_EN SHALL never be high for two consecutive cycles.

Reset
REQ-029 On RST=0, asynchronously and regardless of state, the block SHALL force:
- state=IDLE
- Cross_EN=0, In_Out_Sel=0, Grant=0, Err_done=0, Busy=0
- ptr=PTR_INIT
REQ-030 A reset during ISSUE or CHECK SHALL abort the transfer with no Grant issued.
REQ-031 After reset release, the first arbitration SHALL occur on the first rising edge with RST=1.

Configuration
REQ-032 Macro SWALLOC_STATS_EN defined: add output Grant_cnt (16 bits, reset 0).
- increments on every Grant pulse
- saturates at 16'hFFFF
REQ-033 SWALLOC_STATS_EN undefined: Grant_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-034 Single request:
- stimulus: Req=00001, Dest_W=1, Out_ready=11111, crossbar model responds
- response: Cross_EN pulse with In_Out_Sel=1 one cycle after request; Grant=00001 two cycles after that
REQ-035 Round-robin fairness:
- stimulus: Req=11111 held, all Dest=2 (PE Dest=0), all ready, ptr reset 4
- response: grants in order W, E, N, S, PE, W; Cross_EN pulses every 3 cycles
REQ-036 Masking:
- stimulus: Req=00010, Dest_E=4, Out_ready[4]=0 for 10 cycles, then 1
- response: no Cross_EN while not ready; then In_Out_Sel=9 and Grant=00010
REQ-037 Illegal destinations:
- stimulus: Req=10000, Dest_PE=4; and Req=00001, Dest_W=6
- response: no Cross_EN, no Grant, Busy=0
REQ-038 Missing done:
- stimulus: crossbar model holds all done flags at 0
- response: Err_done pulses once per attempt, Grant stays 0, ptr unchanged, retry from IDLE
REQ-039 Reset in CHECK:
- stimulus: assert RST=0 while in CHECK
- response: all outputs 0 immediately, no Grant; with SWALLOC_STATS_EN, Grant_cnt=0
